// File: rtl/fifo_pkg.sv
// Shared constants for the per-virtual-channel threshold FIFO.
package fifo_pkg;

    localparam int unsigned FIFO_WIDTH      = 6;
    localparam int unsigned FIFO_DEPTH      = 16;
    localparam int unsigned FIFO_PTR_W      = 4;

    localparam int unsigned UMBRAL_BAJO_LSB = 0;
    localparam int unsigned UMBRAL_ALTO_LSB = 4;
    localparam int unsigned UMBRAL_W        = 4;

    localparam int unsigned N_CANALES       = 5;

endpackage

// File: rtl/fifo_mem.sv
// Register-array storage: synchronous write port, registered synchronous read port.
// Contents are not reset; only the read-data register is.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = FIFO_WIDTH,
    parameter int unsigned DEPTH = FIFO_DEPTH,
    parameter int unsigned PTR_W = FIFO_PTR_W
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_wr_en,
    input  logic [PTR_W-1:0] i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    input  logic [PTR_W-1:0] i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Same-address write and read in one cycle returns the old word.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/fifo_umbral.sv
// Single-clock FIFO with programmable low/high occupancy thresholds and error reporting.
// Define FIFO_ERROR_STICKY_EN to make fifo_error latch until reset instead of pulsing.
module fifo_umbral
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = FIFO_WIDTH,
    parameter int unsigned DEPTH = FIFO_DEPTH,
    parameter int unsigned PTR_W = FIFO_PTR_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] data_in,
    input  logic             pop,
    input  logic [7:0]       umbral,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic             fifo_empty,
    output logic             fifo_full,
    output logic             almost_empty,
    output logic             almost_full,
    output logic             fifo_error
);

    localparam int unsigned CMP_W = UMBRAL_W + 1;

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             r_valid;
    logic             r_error;

    logic             w_empty;
    logic             w_full;
    logic             w_pop_ok;
    logic             w_push_ok;
    logic             w_err_ev;
    logic [CMP_W-1:0] w_count_ext;
    logic [CMP_W-1:0] w_umbral_lo;
    logic [CMP_W-1:0] w_umbral_hi;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == (PTR_W+1)'(DEPTH));
    assign w_pop_ok  = pop && !w_empty;
    // A simultaneous accepted pop frees the slot, so a push at full still lands.
    assign w_push_ok = push && (!w_full || w_pop_ok);
    assign w_err_ev  = (push && w_full && !w_pop_ok) || (pop && w_empty);

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .i_clk     (clk),
        .i_reset   (reset),
        .i_wr_en   (w_push_ok),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (data_in),
        .i_rd_en   (w_pop_ok),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (data_out)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= w_pop_ok;
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push_ok && !w_pop_ok) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop_ok && !w_push_ok) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_error <= 1'b0;
        end else begin
`ifdef FIFO_ERROR_STICKY_EN
            r_error <= r_error | w_err_ev;
`else
            r_error <= w_err_ev;
`endif
        end
    end

    assign w_count_ext = CMP_W'(r_count);
    assign w_umbral_lo = {1'b0, umbral[UMBRAL_BAJO_LSB +: UMBRAL_W]};
    assign w_umbral_hi = {1'b0, umbral[UMBRAL_ALTO_LSB +: UMBRAL_W]};

    assign valid_out    = r_valid;
    assign fifo_error   = r_error;
    assign fifo_empty   = w_empty;
    assign fifo_full    = w_full;
    assign almost_empty = (w_count_ext <= w_umbral_lo);
    assign almost_full  = (w_count_ext >= w_umbral_hi);

endmodule

// File: tb/tb_fifo_umbral.sv
// Directed plus randomized checks of fifo_umbral against a queue-based reference model.
module tb_fifo_umbral;

    logic       clk;
    logic       reset;
    logic       push;
    logic [5:0] data_in;
    logic       pop;
    logic [7:0] umbral;
    logic [5:0] data_out;
    logic       valid_out;
    logic       fifo_empty;
    logic       fifo_full;
    logic       almost_empty;
    logic       almost_full;
    logic       fifo_error;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int         m_q[$];
    logic [5:0] m_dout;
    logic       m_valid;
    logic       m_err;

    fifo_umbral dut (
        .clk          (clk),
        .reset        (reset),
        .push         (push),
        .data_in      (data_in),
        .pop          (pop),
        .umbral       (umbral),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .fifo_empty   (fifo_empty),
        .fifo_full    (fifo_full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .fifo_error   (fifo_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_dout  = '0;
        m_valid = 1'b0;
        m_err   = 1'b0;
    endtask

    task automatic check_all(input string ctx);
        int n;
        n = m_q.size();
        check({ctx, " data_out"},     32'(data_out),     32'(m_dout));
        check({ctx, " valid_out"},    32'(valid_out),    32'(m_valid));
        check({ctx, " fifo_empty"},   32'(fifo_empty),   32'(n == 0));
        check({ctx, " fifo_full"},    32'(fifo_full),    32'(n == 16));
        check({ctx, " almost_empty"}, 32'(almost_empty), 32'(n <= int'(umbral[3:0])));
        check({ctx, " almost_full"},  32'(almost_full),  32'(n >= int'(umbral[7:4])));
        check({ctx, " fifo_error"},   32'(fifo_error),   32'(m_err));
    endtask

    // One clock with the given request; model advances at the edge, outputs checked 1 unit later.
    task automatic cycle(input string ctx, input logic p, input logic [5:0] d, input logic q);
        bit pop_ok, push_ok, err_ev, full;
        push    = p;
        data_in = d;
        pop     = q;
        @(posedge clk);
        full    = (m_q.size() == 16);
        pop_ok  = q && (m_q.size() > 0);
        push_ok = p && (!full || pop_ok);
        err_ev  = (p && full && !pop_ok) || (q && m_q.size() == 0);
        if (pop_ok) m_dout = 6'(m_q.pop_front());
        if (push_ok) m_q.push_back(int'(d));
        m_valid = pop_ok;
`ifdef FIFO_ERROR_STICKY_EN
        m_err = m_err | err_ev;
`else
        m_err = err_ev;
`endif
        #1;
        push = 1'b0;
        pop  = 1'b0;
        check_all(ctx);
    endtask

    // Reset asserted between edges must clear state with no clock.
    task automatic async_reset(input string ctx);
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        check_all({ctx, " async"});
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        push    = 1'b0;
        pop     = 1'b0;
        data_in = '0;
        umbral  = 8'h00;
        model_reset();
        #12;
        check_all("reset hi0");
        reset  = 1'b0;
        umbral = 8'hC3;
        #1;
        check_all("reset C3");

        for (int i = 1; i <= 16; i++) cycle("fill", 1'b1, 6'(i), 1'b0);
        check("full after 16", 32'(fifo_full), 32'd1);
        cycle("overflow", 1'b1, 6'h3F, 1'b0);
        check("overflow err", 32'(fifo_error), 32'd1);
        for (int i = 1; i <= 16; i++) begin
            cycle("drain", 1'b0, 6'h00, 1'b1);
            check("drain order", 32'(data_out), 32'(i));
        end
        cycle("underflow", 1'b0, 6'h00, 1'b1);
        check("underflow valid", 32'(valid_out), 32'd0);
        cycle("idle after underflow", 1'b0, 6'h00, 1'b0);

        for (int i = 1; i <= 16; i++) cycle("refill", 1'b1, 6'(i), 1'b0);
        cycle("full push+pop", 1'b1, 6'h2A, 1'b1);
        check("full push+pop dout", 32'(data_out), 32'h01);
        for (int i = 0; i < 16; i++) cycle("drain2", 1'b0, 6'h00, 1'b1);
        check("last word 2A", 32'(data_out), 32'h2A);

        cycle("empty push+pop", 1'b1, 6'h15, 1'b1);
        cycle("pop 15", 1'b0, 6'h00, 1'b1);
        check("pop 15 dout", 32'(data_out), 32'h15);

        for (int i = 0; i < 3; i++) cycle("pre-reset push", 1'b1, 6'(i + 7), 1'b0);
        async_reset("mid-op");
        check("after reset empty", 32'(fifo_empty), 32'd1);
        cycle("pop after reset", 1'b0, 6'h00, 1'b1);
        check("pop after reset err", 32'(fifo_error), 32'd1);

        for (int i = 0; i < 600; i++) begin
            int ppush, ppop;
            if (i % 60 == 0) umbral = 8'($urandom);
            ppush = ((i / 75) % 2 == 0) ? 75 : 25;
            ppop  = 100 - ppush;
            if ($urandom_range(0, 199) == 0) begin
                async_reset("rand");
            end else begin
                cycle("rand", ($urandom_range(0, 99) < ppush), 6'($urandom_range(0, 63)),
                      ($urandom_range(0, 99) < ppop));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
